// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Turns single-word CPU load/store requests into APB3 transfers on the master
// side of the APB address decoder/mux. Runs the IDLE -> SETUP -> ACCESS
// sequence, returns read data to the CPU and aborts with an error when the
// request address is not word aligned or when the slave holds PREADY low for
// TIMEOUT consecutive ACCESS cycles (TIMEOUT = 0 disables the abort).
//
// Handshake: cpu_req is a level request held high until cpu_ack. cpu_ack is a
// one-cycle completion pulse; cpu_err and cpu_rdata qualify it in the same
// cycle. The ack cycle never accepts a request, so a held level request is
// taken at most once per ack.
//
// Ports:
//   PCLK, PRESETn         clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata CPU request side (addr must be word aligned)
//   cpu_rdata/ack/err     CPU completion side, valid while cpu_ack = 1
//   cpu_busy              high while the FSM is outside IDLE
//   M_PSEL..M_PWDATA      APB master outputs toward the mux
//   M_PRDATA, M_PREADY    APB responses returned by the mux
//   fsm_state             current FSM state (debug visibility)
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              cpu_busy,
  output logic              M_PSEL,
  output logic              M_PENABLE,
  output logic              M_PWRITE,
  output logic [ADDR_W-1:0] M_PADDR,
  output logic [DATA_W-1:0] M_PWDATA,
  input  logic [DATA_W-1:0] M_PRDATA,
  input  logic              M_PREADY,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Counter is wide enough to hold TIMEOUT-1; at least one bit when disabled.
  localparam int              CNT_W      = $clog2(TIMEOUT + 2);
  localparam bit              TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state, state_n;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;

  logic              psel_n, penable_n, pwrite_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [DATA_W-1:0] pwdata_n, rdata_n;
  logic              ack_n, err_n, busy_n;

  logic              aligned;
  logic              timeout_hit;

  assign aligned = (cpu_addr[1:0] == 2'b00);

  // wait_cnt holds the number of PREADY-low ACCESS cycles already completed,
  // so the TIMEOUT-th low cycle sees wait_cnt == TIMEOUT-1 and aborts at its
  // closing edge.
  assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    psel_n     = M_PSEL;
    penable_n  = M_PENABLE;
    pwrite_n   = M_PWRITE;
    paddr_n    = M_PADDR;
    pwdata_n   = M_PWDATA;
    rdata_n    = cpu_rdata;
    ack_n      = 1'b0;
    err_n      = 1'b0;

    case (state)
      IDLE: begin
        // The ack cycle is skipped so a held level request is not re-taken.
        if (cpu_req && !cpu_ack) begin
          if (aligned) begin
            state_n    = SETUP;
            psel_n     = 1'b1;
            penable_n  = 1'b0;
            pwrite_n   = cpu_we;
            paddr_n    = cpu_addr;
            pwdata_n   = cpu_wdata;
            wait_cnt_n = '0;
          end else begin
            // Misaligned: no APB activity, immediate error completion.
            ack_n   = 1'b1;
            err_n   = 1'b1;
            rdata_n = '0;
          end
        end
      end

      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
      end

      ACCESS: begin
        if (M_PREADY) begin
          state_n   = IDLE;
          psel_n    = 1'b0;
          penable_n = 1'b0;
          ack_n     = 1'b1;
          // Writes leave the previous read data visible.
          if (!M_PWRITE) begin
            rdata_n = M_PRDATA;
          end
        end else if (timeout_hit) begin
          state_n   = IDLE;
          psel_n    = 1'b0;
          penable_n = 1'b0;
          ack_n     = 1'b1;
          err_n     = 1'b1;
          rdata_n   = '0;
        end else begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n   = IDLE;
        psel_n    = 1'b0;
        penable_n = 1'b0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      M_PSEL    <= 1'b0;
      M_PENABLE <= 1'b0;
      M_PWRITE  <= 1'b0;
      M_PADDR   <= '0;
      M_PWDATA  <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_busy  <= 1'b0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_cnt_n;
      M_PSEL    <= psel_n;
      M_PENABLE <= penable_n;
      M_PWRITE  <= pwrite_n;
      M_PADDR   <= paddr_n;
      M_PWDATA  <= pwdata_n;
      cpu_rdata <= rdata_n;
      cpu_ack   <= ack_n;
      cpu_err   <= err_n;
      cpu_busy  <= busy_n;
    end
  end

  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Embedded protocol properties
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_err_has_ack : assert property (@(posedge PCLK) disable iff (!PRESETn)
    cpu_err |-> cpu_ack);

  a_ack_pulse : assert property (@(posedge PCLK) disable iff (!PRESETn)
    cpu_ack |=> !cpu_ack);

  a_enable_needs_sel : assert property (@(posedge PCLK) disable iff (!PRESETn)
    M_PENABLE |-> M_PSEL);

  a_setup_one_cycle : assert property (@(posedge PCLK) disable iff (!PRESETn)
    (state == SETUP) |=> (state == ACCESS));

  a_access_stable : assert property (@(posedge PCLK) disable iff (!PRESETn)
    ((state == ACCESS) && !M_PREADY && !timeout_hit) |=>
      ((state == ACCESS) && $stable(M_PADDR) && $stable(M_PWRITE) && $stable(M_PWDATA)));
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Directed bench for apb_master_bridge. The driver pushes {err, rdata}
// expectations into exp_q when it issues a request; a separate monitor pops
// and compares on every cpu_ack. Cycle-level APB checks are made inline by
// the test sequence. A small APB slave model answers with a programmable
// number of wait states (or never, for the timeout and reset cases).
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] IDLE_DATA = 32'hBAD0_0000;

  logic              PCLK;
  logic              PRESETn;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_err;
  logic              cpu_busy;
  logic              M_PSEL;
  logic              M_PENABLE;
  logic              M_PWRITE;
  logic [ADDR_W-1:0] M_PADDR;
  logic [DATA_W-1:0] M_PWDATA;
  logic [DATA_W-1:0] M_PRDATA;
  logic              M_PREADY;
  logic [1:0]        fsm_state;

  apb_master_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .cpu_err  (cpu_err),
    .cpu_busy (cpu_busy),
    .M_PSEL   (M_PSEL),
    .M_PENABLE(M_PENABLE),
    .M_PWRITE (M_PWRITE),
    .M_PADDR  (M_PADDR),
    .M_PWDATA (M_PWDATA),
    .M_PRDATA (M_PRDATA),
    .M_PREADY (M_PREADY),
    .fsm_state(fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [DATA_W:0] exp_q[$];   // {err, rdata}
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // APB slave model: ready after slave_wait low ACCESS cycles
  // ---------------------------------------------------------------------------
  int          slave_wait = 0;
  logic [31:0] slave_data = 32'h0;
  int          slave_cnt  = 0;

  initial begin
    M_PREADY = 1'b0;
    M_PRDATA = IDLE_DATA;
    forever begin
      @(negedge PCLK);
      if (M_PSEL && M_PENABLE) begin
        if (slave_cnt >= slave_wait) begin
          M_PREADY = 1'b1;
          M_PRDATA = slave_data;
        end else begin
          M_PREADY = 1'b0;
          M_PRDATA = IDLE_DATA;
        end
        slave_cnt++;
      end else begin
        M_PREADY  = 1'b0;
        M_PRDATA  = IDLE_DATA;
        slave_cnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops one expectation per cpu_ack
  // ---------------------------------------------------------------------------
  initial begin
    logic [DATA_W:0] e;
    forever begin
      @(negedge PCLK);
      if (cpu_err) check("err_needs_ack", cpu_ack, 1);
      if (cpu_ack) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got cpu_ack=1 expected no ack (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("ack_err", cpu_err, e[DATA_W]);
          check("ack_rdata", cpu_rdata, e[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge)
  // ---------------------------------------------------------------------------
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata, input bit push);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    if (push) exp_q.push_back({exp_err, exp_rdata});
  endtask

  // Steps negedges until cpu_ack, checking APB fields during ACCESS.
  task automatic watch(input string name, input int max_cyc, input logic [31:0] exp_addr,
                       input logic exp_write, input logic [31:0] exp_wdata,
                       output int n_cyc, output int n_access);
    bit acked;
    acked    = 0;
    n_cyc    = 0;
    n_access = 0;
    while (!acked && n_cyc < max_cyc) begin
      @(negedge PCLK);
      n_cyc++;
      if (cpu_ack) begin
        acked = 1;
        check({name, "_psel_at_ack"}, M_PSEL, 0);
        check({name, "_busy_at_ack"}, cpu_busy, 0);
      end else begin
        check({name, "_busy"}, cpu_busy, 1);
        if (M_PSEL && M_PENABLE) begin
          n_access++;
          check({name, "_paddr"}, M_PADDR, exp_addr);
          check({name, "_pwrite"}, M_PWRITE, exp_write);
          if (exp_write) check({name, "_pwdata"}, M_PWDATA, exp_wdata);
        end
      end
    end
    cpu_req = 1'b0;
    if (!acked) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_ack_timeout: got no cpu_ack expected one within %0d cycles", name, max_cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [31:0] b2b_addr [3] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
  logic [31:0] b2b_data [3] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033};

  initial begin
    int n_cyc, n_access;
    int setups, acks, last_ack;

    PRESETn   = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (3) @(negedge PCLK);
    check("rst_ctrl", {M_PSEL, M_PENABLE, M_PWRITE, cpu_ack, cpu_err, cpu_busy}, 6'b0);
    check("rst_paddr", M_PADDR, 0);
    check("rst_pwdata", M_PWDATA, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_state", fsm_state, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Write 0x24 <= 0xA5, zero-wait slave.
    slave_wait = 0;
    issue(1'b1, 32'h24, 32'hA5, 1'b0, 32'h0, 1);
    @(negedge PCLK);
    check("wr_setup_psel", M_PSEL, 1);
    check("wr_setup_penable", M_PENABLE, 0);
    check("wr_setup_busy", cpu_busy, 1);
    @(negedge PCLK);
    check("wr_access_ctrl", {M_PSEL, M_PENABLE, M_PWRITE}, 3'b111);
    check("wr_access_paddr", M_PADDR, 32'h24);
    check("wr_access_pwdata", M_PWDATA, 32'hA5);
    watch("wr", 10, 32'h24, 1'b1, 32'hA5, n_cyc, n_access);
    check("wr_ack_latency", n_cyc, 1);
    @(negedge PCLK);

    // Read 0x3004 with 3 wait states; CPU inputs change mid-transfer.
    slave_wait = 3;
    slave_data = 32'hDEAD_BEEF;
    issue(1'b0, 32'h3004, 32'h0, 1'b0, 32'hDEAD_BEEF, 1);
    @(negedge PCLK);
    check("rd_setup_busy", cpu_busy, 1);
    check("rd_setup_sel", {M_PSEL, M_PENABLE}, 2'b10);
    cpu_addr  = 32'hFFFF_FFF0;
    cpu_we    = 1'b1;
    cpu_wdata = 32'h5555_AAAA;
    watch("rd", 20, 32'h3004, 1'b0, 32'h0, n_cyc, n_access);
    check("rd_access_cycles", n_access, 4);
    @(negedge PCLK);

    // Reset asserted mid-ACCESS with the slave stalled.
    slave_wait = 1000000;
    issue(1'b1, 32'h40, 32'h9999, 1'b0, 32'h0, 0);
    repeat (3) @(negedge PCLK);
    check("rstmid_in_access", {M_PSEL, M_PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    check("rstmid_ctrl", {M_PSEL, M_PENABLE, M_PWRITE, cpu_ack, cpu_err, cpu_busy}, 6'b0);
    check("rstmid_paddr", M_PADDR, 0);
    check("rstmid_pwdata", M_PWDATA, 0);
    check("rstmid_rdata", cpu_rdata, 0);
    check("rstmid_state", fsm_state, 0);
    cpu_req = 1'b0;
    repeat (2) begin
      @(negedge PCLK);
      check("rstmid_no_ack", cpu_ack, 0);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("rstmid_post_idle", {M_PSEL, cpu_ack, cpu_busy}, 3'b0);

    // Fresh read of 0x20 after reset.
    slave_wait = 0;
    slave_data = 32'h1234_5678;
    issue(1'b0, 32'h20, 32'h0, 1'b0, 32'h1234_5678, 1);
    watch("rd20", 10, 32'h20, 1'b0, 32'h0, n_cyc, n_access);
    check("rd20_latency", n_cyc, 3);
    check("rd20_access_cycles", n_access, 1);
    @(negedge PCLK);

    // Three back-to-back writes with cpu_req held high; rdata must hold.
    setups   = 0;
    acks     = 0;
    last_ack = -1;
    issue(1'b1, b2b_addr[0], b2b_data[0], 1'b0, 32'h1234_5678, 1);
    for (int i = 0; i < 40 && acks < 3; i++) begin
      @(negedge PCLK);
      if (M_PSEL && !M_PENABLE) begin
        setups++;
        if (last_ack >= 0) check("b2b_setup_gap", cyc - last_ack, 2);
      end
      if (M_PSEL && M_PENABLE) begin
        check("b2b_paddr", M_PADDR, b2b_addr[acks]);
        check("b2b_pwdata", M_PWDATA, b2b_data[acks]);
      end
      if (cpu_ack) begin
        check("b2b_no_setup_in_ack", M_PSEL, 0);
        acks++;
        last_ack = cyc;
        if (acks < 3) issue(1'b1, b2b_addr[acks], b2b_data[acks], 1'b0, 32'h1234_5678, 1);
        else cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    check("b2b_acks", acks, 3);
    check("b2b_setups", setups, 3);
    @(negedge PCLK);

    // Read 0x10 against a slave that never answers: abort after 16 ACCESS cycles.
    slave_wait = 1000000;
    issue(1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1);
    watch("tmo", 40, 32'h10, 1'b0, 32'h0, n_cyc, n_access);
    check("tmo_access_cycles", n_access, 16);
    @(negedge PCLK);

    // Misaligned request to 0x22: no APB activity, error one cycle later.
    slave_wait = 0;
    issue(1'b1, 32'h22, 32'h55, 1'b1, 32'h0, 1);
    watch("mis", 10, 32'h22, 1'b1, 32'h55, n_cyc, n_access);
    check("mis_latency", n_cyc, 1);
    check("mis_access_cycles", n_access, 0);
    @(negedge PCLK);
    check("mis_psel_after", {M_PSEL, cpu_busy}, 2'b0);

    repeat (3) @(negedge PCLK);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
